// File: rtl/nand_equiv_sweeper.sv
// Self-running equivalence sweep of s = a | ~b against its NAND-only form
// ~(~(a&a) & b), with fault injection on the NAND path and first-failure capture.
module nand_equiv_sweeper #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inj_en,
    input  logic [WIDTH-1:0] inj_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    localparam int unsigned VEC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = VEC_W + 1;
    localparam int unsigned N_VEC = 1 << VEC_W;
    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(N_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   a1_q, a1_d, b1_q, b1_d;
    logic               v2_q, v2_d;
    logic [WIDTH-1:0]   a2_q, a2_d, b2_q, b2_d;
    logic [WIDTH-1:0]   ref_q, ref_d, eq_q, eq_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fv_q, fv_d;
    logic [WIDTH-1:0]   ffa_q, ffa_d, ffb_q, ffb_d;

    // NAND-only form built strictly from 2-input nand gates
    logic [WIDTH-1:0]   nand_aa;
    logic [WIDTH-1:0]   nand_out;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_nand
        nand u_aa  (nand_aa[i],  a1_q[i],    a1_q[i]);
        nand u_out (nand_out[i], nand_aa[i], b1_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            v2_q    <= 1'b0;
            a2_q    <= '0;
            b2_q    <= '0;
            ref_q   <= '0;
            eq_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffa_q   <= '0;
            ffb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            v2_q    <= v2_d;
            a2_q    <= a2_d;
            b2_q    <= b2_d;
            ref_q   <= ref_d;
            eq_q    <= eq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffa_q   <= ffa_d;
            ffb_q   <= ffb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v1_d    = 1'b0;
        a1_d    = a1_q;
        b1_d    = b1_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ffa_d   = ffa_q;
        ffb_d   = ffb_q;

        // Stage 2: reference vs. (optionally corrupted) NAND form
        v2_d  = v1_q;
        a2_d  = a1_q;
        b2_d  = b1_q;
        ref_d = a1_q | ~b1_q;
        eq_d  = nand_out ^ (inj_en ? inj_mask : '0);

        // Accumulate: one count per mismatching vector, first failure latched
        if (v2_q && (ref_q != eq_q)) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!fv_q) begin
                fv_d  = 1'b1;
                ffa_d = a2_q;
                ffb_d = b2_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SWEEP;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffa_d   = '0;
                    ffb_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_SWEEP: begin
                v1_d  = 1'b1;
                a1_d  = cnt_q[VEC_W-1:WIDTH];
                b1_d  = cnt_q[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_VEC) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Exit only once both pipeline stages are empty
                if (!v1_q && !v2_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign fail_valid   = fv_q;
    assign first_fail_a = ffa_q;
    assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_nand_equiv_sweeper.sv
// Bench for nand_equiv_sweeper: cycle model of the sweep timeline for the main
// instance plus literal end-of-sweep expectations for saturation and WIDTH=1.
module tb_nand_equiv_sweeper;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance: WIDTH=2, ERR_W=8
    logic       start, inj_en;
    logic [1:0] inj_mask;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_count;
    logic [1:0] ffa, ffb;

    // saturation instance: WIDTH=2, ERR_W=3
    logic       s_start, s_inj_en;
    logic [1:0] s_inj_mask;
    logic       s_busy, s_done, s_pass, s_fv;
    logic [2:0] s_err;
    logic [1:0] s_ffa, s_ffb;

    // narrow instance: WIDTH=1, ERR_W=8
    logic       w_start, w_inj_en;
    logic [0:0] w_inj_mask;
    logic       w_busy, w_done, w_pass, w_fv;
    logic [7:0] w_err;
    logic [0:0] w_ffa, w_ffb;

    nand_equiv_sweeper #(.WIDTH(2), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inj_en(inj_en), .inj_mask(inj_mask),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail_a(ffa), .first_fail_b(ffb)
    );

    nand_equiv_sweeper #(.WIDTH(2), .ERR_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .inj_en(s_inj_en), .inj_mask(s_inj_mask),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .fail_valid(s_fv), .first_fail_a(s_ffa), .first_fail_b(s_ffb)
    );

    nand_equiv_sweeper #(.WIDTH(1), .ERR_W(8)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .start(w_start), .inj_en(w_inj_en), .inj_mask(w_inj_mask),
        .busy(w_busy), .done(w_done), .pass(w_pass), .err_count(w_err),
        .fail_valid(w_fv), .first_fail_a(w_ffa), .first_fail_b(w_ffb)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: timeline counted in edges since the accepting edge (k=0).
    // Vector j is judged with the inj inputs seen at edge j+2 and lands at edge j+3;
    // done appears at edge N+3.
    bit         m_active, m_busy, m_done, m_pass, m_fv;
    int         m_k, m_err;
    logic [1:0] m_fa, m_fb;
    bit         p_v, p_mis;
    logic [1:0] p_a, p_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_busy = 0; m_done = 0; m_pass = 0; m_fv = 0;
            m_k = 0; m_err = 0; m_fa = '0; m_fb = '0; p_v = 0; p_mis = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_k = 0; m_busy = 1; m_err = 0; m_fv = 0;
                    m_fa = '0; m_fb = '0; m_pass = 0; p_v = 0;
                end
            end else begin
                logic [1:0] va, vb, ref_v, nand_v, eq_v;
                m_k++;
                if (p_v && p_mis) begin
                    if (m_err < 255) m_err++;
                    if (!m_fv) begin m_fv = 1; m_fa = p_a; m_fb = p_b; end
                end
                p_v = 0;
                if (m_k >= 2 && m_k <= N + 1) begin
                    va     = 2'((m_k - 2) >> 2);
                    vb     = 2'((m_k - 2) & 3);
                    ref_v  = va | ~vb;
                    nand_v = ~(~va & vb);
                    eq_v   = nand_v ^ (inj_en ? inj_mask : 2'b00);
                    p_v = 1; p_mis = (ref_v != eq_v); p_a = va; p_b = vb;
                end
                if (m_k == N + 3) begin
                    m_active = 0; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("pass", 32'(pass), 32'(m_pass));
            check("err_count", 32'(err_count), 32'(m_err));
            check("fail_valid", 32'(fail_valid), 32'(m_fv));
            check("first_fail_a", 32'(ffa), 32'(m_fa));
            check("first_fail_b", 32'(ffb), 32'(m_fb));
        end
    end

    task automatic run_sweep(input bit base_inj, input logic [1:0] mask, input int inj_edge,
                             input int restart_at, output int lat, output int bc);
        inj_en = base_inj; inj_mask = mask; start = 1'b1;
        step();
        start = 1'b0; lat = 0; bc = 0;
        while (!done && lat < 60) begin
            if (busy) bc++;
            start  = (lat == restart_at);
            inj_en = base_inj || (lat + 1 == inj_edge);
            step();
            lat++;
        end
        start = 1'b0; inj_en = 1'b0;
        if (!done) check("sweep_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, bc, pulses;
        rst_n = 1'b0; start = 0; inj_en = 0; inj_mask = '0;
        s_start = 0; s_inj_en = 0; s_inj_mask = '0;
        w_start = 0; w_inj_en = 0; w_inj_mask = '0;
        repeat (3) step();
        cmp_en = 1'b1;

        // T1: reset state and idle without start
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin step(); if (done) pulses++; end
        check("idle_no_done", 32'(pulses), 32'd0);

        // T2: clean sweep
        run_sweep(1'b0, 2'b00, -1, -1, lat, bc);
        check("t2_latency", 32'(lat), 32'd19);
        check("t2_busy_cycles", 32'(bc), 32'd19);
        check("t2_pass", 32'(pass), 32'd1);
        check("t2_err", 32'(err_count), 32'd0);
        check("t2_fv", 32'(fail_valid), 32'd0);
        step();
        check("t2_done_pulse", 32'(done), 32'd0);

        // T3: full injection
        run_sweep(1'b1, 2'b01, -1, -1, lat, bc);
        check("t3_err", 32'(err_count), 32'd16);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_fv", 32'(fail_valid), 32'd1);
        check("t3_ffa", 32'(ffa), 32'd0);
        check("t3_ffb", 32'(ffb), 32'd0);

        // T4: injection only on the stage-2 edge of a=2,b=1 (vector 9 -> edge 11)
        run_sweep(1'b0, 2'b11, 11, -1, lat, bc);
        check("t4_err", 32'(err_count), 32'd1);
        check("t4_ffa", 32'(ffa), 32'd2);
        check("t4_ffb", 32'(ffb), 32'd1);
        check("t4_pass", 32'(pass), 32'd0);
        repeat (5) step();
        check("t4_hold_err", 32'(err_count), 32'd1);
        run_sweep(1'b1, 2'b00, -1, -1, lat, bc);
        check("t4_zero_mask_err", 32'(err_count), 32'd0);
        check("t4_zero_mask_pass", 32'(pass), 32'd1);

        // T5: start while busy is ignored
        run_sweep(1'b0, 2'b00, -1, 5, lat, bc);
        check("t5_restart_latency", 32'(lat), 32'd19);
        pulses = 0;
        repeat (25) begin step(); if (done || busy) pulses++; end
        check("t5_single_sweep", 32'(pulses), 32'd0);

        // T5: reset mid-sweep with errors already counted
        inj_en = 1'b1; inj_mask = 2'b01; start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("t5_err_before_rst", 32'(err_count), 32'd6);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_err", 32'(err_count), 32'd0);
        check("t5_rst_fv", 32'(fail_valid), 32'd0);
        inj_en = 1'b0;
        pulses = 0;
        repeat (10) begin step(); if (done) pulses++; end
        check("t5_rst_no_done", 32'(pulses), 32'd0);
        rst_n = 1'b1;
        step();
        run_sweep(1'b0, 2'b00, -1, -1, lat, bc);
        check("t5_after_rst_lat", 32'(lat), 32'd19);
        check("t5_after_rst_pass", 32'(pass), 32'd1);

        // start held through done re-starts on the following edge
        start = 1'b1;
        step();
        lat = 0;
        while (!done && lat < 60) begin step(); lat++; end
        check("hold_start_lat", 32'(lat), 32'd19);
        step();
        check("hold_start_restart", 32'(busy), 32'd1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin step(); lat++; end
        check("hold_start_lat2", 32'(lat), 32'd19);

        // T6: saturation at ERR_W=3
        s_inj_en = 1'b1; s_inj_mask = 2'b01; s_start = 1'b1;
        step();
        s_start = 1'b0; lat = 0;
        while (!s_done && lat < 60) begin step(); lat++; end
        check("t6_sat_lat", 32'(lat), 32'd19);
        check("t6_sat_err", 32'(s_err), 32'd7);
        check("t6_sat_pass", 32'(s_pass), 32'd0);
        check("t6_sat_fv", 32'(s_fv), 32'd1);
        s_inj_en = 1'b0;

        // T6: WIDTH=1 clean sweep
        w_start = 1'b1;
        step();
        w_start = 1'b0; lat = 0;
        while (!w_done && lat < 60) begin step(); lat++; end
        check("t6_w1_lat", 32'(lat), 32'd7);
        check("t6_w1_pass", 32'(w_pass), 32'd1);
        check("t6_w1_err", 32'(w_err), 32'd0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
